if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The parameter list SHALL be exactly as follows.
- DEPTH, 2: number of buffered fetch entries; power of two, 2..8.
- PTR_W, 1: pointer width, log2(DEPTH).
REQ-002 The port list SHALL be exactly as follows, clock and reset first.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- if_pc  input  32  PC of the fetched instruction.
- if_inst  input  32  fetched instruction word.
- if_valid  input  1  fetch offers a beat.
- if_ready  output  1  queue accepts a beat.
- id_pc  output  32  PC of the head entry.
- id_inst  output  32  instruction of the head entry.
- id_valid  output  1  head entry is valid.
- id_ready  input  1  decode consumes the head this cycle.
- flush  input  1  branch/exception squash; discard all entries.
- count  output  PTR_W+1  number of occupied entries.

Function
REQ-003 A beat SHALL be accepted on a rising edge when if_valid && if_ready.
REQ-004 A beat SHALL be retired on a rising edge when id_valid && id_ready.
REQ-005 Storage SHALL be a circular buffer with wr_ptr and rd_ptr that wrap from DEPTH-1 to 0; count SHALL be maintained as a separate register.
REQ-006 The FSM SHALL have states EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH), encoded in the state register and kept consistent with count.
REQ-007 FSM transitions SHALL be as follows.
- Accept only: EMPTY->PARTIAL, or EMPTY->FULL when DEPTH=1 (not permitted); PARTIAL->FULL when count reaches DEPTH.
- Retire only: FULL->PARTIAL; PARTIAL->EMPTY when count reaches 0.
- Accept and retire together: state and count unchanged, both pointers advance.
REQ-008 if_ready SHALL be 1 when the state is not FULL, and 1 in FULL when id_ready=1 (pass-through while full). It SHALL be a combinational function of state and id_ready only, with no dependency on if_valid.
REQ-009 id_valid SHALL be 1 exactly when the state is not EMPTY. id_pc and id_inst SHALL present the entry at rd_ptr.
REQ-010 When id_valid=0, id_pc SHALL be 32'h0 and id_inst SHALL be 32'h0 (NOP).
REQ-011 Latency SHALL be one cycle: a beat accepted at edge N SHALL appear on id_* after edge N, with no combinational if_* to id_* path.
REQ-012 flush=1 at an edge SHALL force count=0, wr_ptr=rd_ptr=0 and state EMPTY. Any same-cycle accept and retire SHALL be ignored: the incoming beat is dropped and no retire is counted.
REQ-013 flush SHALL take priority over every other event. if_ready SHALL NOT be gated by flush.
REQ-014 Data order SHALL be strict FIFO. Overflow and underflow SHALL be impossible by construction, since writes are ignored when not if_ready and reads are ignored when not id_valid.
REQ-015 id_ready asserted while EMPTY SHALL have no effect.

Reset
REQ-016 rst=0 SHALL asynchronously set count=0, wr_ptr=0, rd_ptr=0 and state EMPTY.
REQ-017 During reset, outputs SHALL be id_valid=0, id_pc=0, id_inst=0 and if_ready=1.
REQ-018 Entry storage SHALL NOT require reset.
REQ-019 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-020 Deassertion of reset SHALL be followed by normal operation from the first rising edge.

Structure
REQ-021 The shared defines file SHALL hold the following constants: ZERO_WORD (32'h0), NOP_INST (32'h0), RST_ENABLE (1'b0), and the state codes Q_EMPTY, Q_PARTIAL, Q_FULL (2 bits).
REQ-022 One sub-module is natural: if_id_entry_mem, a DEPTH x 64 register array holding {pc, inst}, with one write port and an asynchronous read port. Pointers, count and FSM SHALL live in if_id_queue.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios.
- Reset then idle: rst=0 for 195 ns, then released -> id_valid=0, if_ready=1, count=0, id_inst=0.
- Streaming: id_ready=1; pc 0x0,0x4,0x8 with inst 0x34011100,0x34020020,0x3403ff00 -> each appears one cycle later in order; count stays <=1.
- Fill: id_ready=0; push 0x0/0x4 -> count=2, FULL, if_ready=0; third beat 0x8 is held by fetch, then accepted only when id_ready=1.
- Full pass-through: FULL, if_valid=id_ready=1 -> retire 0x0, accept 0x8, count stays 2; next head is 0x4.
- Flush with simultaneous events: count=2, flush=if_valid=id_ready=1 -> next cycle count=0, id_valid=0; later push 0x20 -> head is 0x20.
- Async reset mid-stream: count=2, rst=0 between edges -> id_valid drops before the next edge; wr_ptr wrap verified over 2*DEPTH+1 beats with no reordering.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_queue_pkg
//  Purpose  : Shared constants, state codes and helpers for the IF/ID queue.
//  Revision : 1.0 - initial release
// ============================================================================
package if_id_queue_pkg;

  localparam logic [31:0] ZERO_WORD  = 32'h0;
  localparam logic [31:0] NOP_INST   = 32'h0;
  localparam logic        RST_ENABLE = 1'b0;

  localparam logic [1:0]  Q_EMPTY    = 2'd0;
  localparam logic [1:0]  Q_PARTIAL  = 2'd1;
  localparam logic [1:0]  Q_FULL     = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY   = Q_EMPTY,
    ST_PARTIAL = Q_PARTIAL,
    ST_FULL    = Q_FULL
  } q_state_e;

  // Occupancy class for a given entry count; keeps state and count in lockstep.
  function automatic q_state_e state_of_count(input int occ, input int depth);
    if (occ == 0)          return ST_EMPTY;
    else if (occ == depth) return ST_FULL;
    else                   return ST_PARTIAL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_entry_mem.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_entry_mem
//  Purpose  : DEPTH x 64 entry array holding {pc, inst}; one synchronous
//             write port, one asynchronous read port. No reset on storage.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_entry_mem #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [63:0]      wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [63:0]      rdata
);

  logic [63:0] mem_q [DEPTH];

  // Write the accepted fetch beat into its slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_queue
//  Purpose  : Fetch-to-decode skid queue. Circular buffer with separate count
//             register and EMPTY/PARTIAL/FULL state; flush squashes contents.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    if_pc,
  input  logic [31:0]    if_inst,
  input  logic           if_valid,
  output logic           if_ready,
  output logic [31:0]    id_pc,
  output logic [31:0]    id_inst,
  output logic           id_valid,
  input  logic           id_ready,
  input  logic           flush,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  q_state_e         state_q, state_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic             w_accept;
  logic             w_retire;
  logic [63:0]      w_head;

  // Handshake qualifiers; if_ready looks only at state and id_ready.
  always_comb begin
    if_ready = (state_q != ST_FULL) || id_ready;
    id_valid = (state_q != ST_EMPTY);
    w_accept = if_valid && if_ready;
    w_retire = id_valid && id_ready;
  end

  // Next pointers, count and state; flush overrides any same-cycle traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = ST_EMPTY;
    end else begin
      if (w_accept) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_retire) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({w_accept, w_retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      state_d = state_of_count(int'(count_d), DEPTH);
    end
  end

  // Control state register; reset empties the queue without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  if_id_entry_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_accept && !flush),
    .waddr (wr_ptr_q),
    .wdata ({if_pc, if_inst}),
    .raddr (rd_ptr_q),
    .rdata (w_head)
  );

  // Head presentation; an empty queue shows a zero PC and a NOP.
  always_comb begin
    id_pc   = id_valid ? w_head[63:32] : ZERO_WORD;
    id_inst = id_valid ? w_head[31:0]  : NOP_INST;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_queue
//  Purpose  : Self-checking bench for if_id_queue against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int PTR_W = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      if_pc = '0;
  logic [31:0]      if_inst = '0;
  logic             if_valid = 1'b0;
  logic             if_ready;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             id_ready = 1'b0;
  logic             flush = 1'b0;
  logic [PTR_W:0]   count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .flush    (flush),
    .count    (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {pc, inst} beats.
  logic [63:0] mq[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      bit rdy, acc, ret;
      rdy = (mq.size() < DEPTH) || id_ready;
      acc = if_valid && rdy;
      ret = (mq.size() > 0) && id_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (ret) void'(mq.pop_front());
        if (acc) mq.push_back({if_pc, if_inst});
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [63:0] head;
    head = (mq.size() > 0) ? mq[0] : 64'h0;
    chk("m_id_valid", {31'h0, id_valid}, {31'h0, (mq.size() > 0)});
    chk("m_id_pc",    id_pc,   head[63:32]);
    chk("m_id_inst",  id_inst, head[31:0]);
    chk("m_count",    {30'h0, count}, mq.size());
    chk("m_if_ready", {31'h0, if_ready}, {31'h0, ((mq.size() < DEPTH) || id_ready)});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  initial begin
    // Reset then idle.
    #195;
    rst = 1'b1;
    cyc();
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_if_ready", {31'h0, if_ready}, 32'h1);
    chk("rst_count",    {30'h0, count}, 32'h0);
    chk("rst_id_inst",  id_inst, 32'h0);

    // Streaming with decode always ready.
    id_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h34011100); cyc();
    chk("str0_pc", id_pc, 32'h0);
    chk("str0_inst", id_inst, 32'h34011100);
    chk("str0_count", {30'h0, count}, 32'h1);
    drive(1'b1, 32'h4, 32'h34020020); cyc();
    chk("str1_pc", id_pc, 32'h4);
    chk("str1_inst", id_inst, 32'h34020020);
    chk("str1_count", {30'h0, count}, 32'h1);
    drive(1'b1, 32'h8, 32'h3403ff00); cyc();
    chk("str2_pc", id_pc, 32'h8);
    chk("str2_inst", id_inst, 32'h3403ff00);
    drive(1'b0, 32'h0, 32'h0); cyc();
    chk("str_drain", {30'h0, count}, 32'h0);

    // Fill to FULL with decode stalled.
    id_ready = 1'b0;
    drive(1'b1, 32'h0, 32'h34011100); cyc();
    drive(1'b1, 32'h4, 32'h34020020); cyc();
    chk("fill_count", {30'h0, count}, 32'h2);
    chk("fill_ready", {31'h0, if_ready}, 32'h0);
    chk("fill_head", id_pc, 32'h0);
    drive(1'b1, 32'h8, 32'h3403ff00); cyc();
    chk("hold_count", {30'h0, count}, 32'h2);
    chk("hold_head", id_pc, 32'h0);

    // Full pass-through: retire 0x0 and accept 0x8 on the same edge.
    id_ready = 1'b1;
    #1;
    chk("pt_ready", {31'h0, if_ready}, 32'h1);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    id_ready = 1'b0;
    chk("pt_count", {30'h0, count}, 32'h2);
    chk("pt_head", id_pc, 32'h4);

    // Flush with simultaneous accept and retire.
    flush = 1'b1; id_ready = 1'b1;
    drive(1'b1, 32'hC, 32'h11111111); cyc();
    flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_count", {30'h0, count}, 32'h0);
    chk("fl_valid", {31'h0, id_valid}, 32'h0);
    chk("fl_pc", id_pc, 32'h0);
    drive(1'b1, 32'h20, 32'h22222222); cyc();
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_push", id_pc, 32'h20);

    // Asynchronous reset mid-stream.
    drive(1'b1, 32'h24, 32'h33333333); cyc();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_pre", {30'h0, count}, 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", {31'h0, id_valid}, 32'h0);
    chk("ar_count", {30'h0, count}, 32'h0);
    chk("ar_ready", {31'h0, if_ready}, 32'h1);
    cyc();
    rst = 1'b1;

    // Pointer wrap over 2*DEPTH+1 beats, decode stalling at random.
    for (int i = 0; i < 2*DEPTH+1; i++) begin
      drive(1'b1, 32'h100 + 32'(4*i), 32'hA0000000 + 32'(i));
      id_ready = 1'($urandom_range(0, 1));
      cyc();
      while (!(if_ready || id_ready) && 0) cyc();
    end
    drive(1'b0, 32'h0, 32'h0);
    id_ready = 1'b1;
    repeat (DEPTH + 1) cyc();

    // Randomized traffic including occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom);
      id_ready = 1'($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 200) == 0) begin
        #2 rst = 1'b0;
        #1;
        chk("rnd_ar_valid", {31'h0, id_valid}, 32'h0);
        cyc();
        rst = 1'b1;
      end else begin
        cyc();
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    flush = 1'b0;
    id_ready = 1'b0;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
